// File: rtl/axis_fmcw_unframe.sv
// FMCW receive-side unframer: checks FFT frame alignment and forwards bins [start, start+count).
// Optional AXIS_FMCW_UNFRAME_TUSER_EN adds m_axis_data_tuser carrying each output beat's bin index.
module axis_fmcw_unframe #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [31:0]                 cfg_data,
  output logic                        err_frame,
  output logic [15:0]                 err_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                        s_axis_data_tvalid,
  input  logic                        s_axis_data_tlast,
  output logic                        s_axis_data_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_data_tdata,
`ifdef AXIS_FMCW_UNFRAME_TUSER_EN
  output logic [CNT_WIDTH-1:0]        m_axis_data_tuser,
`endif
  output logic                        m_axis_data_tvalid,
  output logic                        m_axis_data_tlast,
  input  logic                        m_axis_data_tready
);

  localparam logic [4:0]         MAX_LOG2 = 5'(CNT_WIDTH);
  localparam logic [CNT_WIDTH:0] ONE_W    = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] ONE_I  = CNT_WIDTH'(1);

  typedef enum logic {ST_RUN, ST_SYNC} state_t;

  state_t                        state_q;
  logic [CNT_WIDTH-1:0]          idx_q;
  logic [CNT_WIDTH:0]            start_q;
  logic [CNT_WIDTH:0]            end_q;
  logic [CNT_WIDTH-1:0]          last_q;
  logic                          m_tvalid_q;
  logic                          m_tlast_q;
  logic [AXIS_TDATA_WIDTH-1:0]   m_tdata_q;
  logic                          err_frame_q;
  logic [15:0]                   err_count_q;

  logic [4:0]           cfg_log2;
  logic [CNT_WIDTH:0]   cfg_size;
  logic [CNT_WIDTH:0]   cfg_start;
  logic [CNT_WIDTH:0]   cfg_sum;
  logic [CNT_WIDTH:0]   cfg_end;
  logic [CNT_WIDTH-1:0] cfg_last;
  logic [CNT_WIDTH:0]   cur_start;
  logic [CNT_WIDTH:0]   cur_end;
  logic [CNT_WIDTH-1:0] cur_last;
  logic [CNT_WIDTH:0]   idx_w;
  logic                 at_start;
  logic                 at_last;
  logic                 sel;
  logic                 is_end;
  logic                 frame_err;
  logic                 s_xfer;
  logic                 unused_cfg;

  assign unused_cfg = ^cfg_data[31:29];

  // On the first beat of a frame the live config is used directly and also latched,
  // so a new config applies from bin 0 without an extra pipeline stage.
  always_comb begin
    cfg_log2 = cfg_data[4:0];
    if (cfg_log2 == 5'd0 || cfg_log2 > MAX_LOG2) cfg_log2 = MAX_LOG2;
    cfg_size  = ONE_W << cfg_log2;
    cfg_start = (CNT_WIDTH+1)'(cfg_data[16:5]);
    cfg_sum   = cfg_start + (CNT_WIDTH+1)'(cfg_data[28:17]);
    cfg_end   = (cfg_sum < cfg_size) ? cfg_sum : cfg_size;
    cfg_last  = CNT_WIDTH'(cfg_size - ONE_W);

    at_start  = (idx_q == '0);
    cur_start = at_start ? cfg_start : start_q;
    cur_end   = at_start ? cfg_end   : end_q;
    cur_last  = at_start ? cfg_last  : last_q;

    idx_w     = {1'b0, idx_q};
    sel       = (idx_w >= cur_start) && (idx_w < cur_end);
    is_end    = (idx_w == cur_end - ONE_W);
    at_last   = (idx_q == cur_last);
    frame_err = at_last ^ s_axis_data_tlast;
  end

  assign s_axis_data_tready = (state_q == ST_SYNC) ? 1'b1 : (~m_tvalid_q | m_axis_data_tready);
  assign s_xfer             = s_axis_data_tvalid & s_axis_data_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_RUN;
      idx_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      last_q      <= '1;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      err_frame_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_frame_q <= 1'b0;
      if (m_tvalid_q && m_axis_data_tready) m_tvalid_q <= 1'b0;
      if (s_xfer) begin
        case (state_q)
          ST_RUN: begin
            if (at_start) begin
              start_q <= cfg_start;
              end_q   <= cfg_end;
              last_q  <= cfg_last;
            end
            // A selected beat that ends a frame in error closes the output frame itself.
            // A stalled output beat cannot coexist with an input transfer, so no other
            // output beat ever needs its tlast patched.
            if (sel) begin
              m_tvalid_q <= 1'b1;
              m_tdata_q  <= s_axis_data_tdata;
              m_tlast_q  <= is_end | frame_err;
            end
            if (frame_err) begin
              err_frame_q <= 1'b1;
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            end
            if (at_last && !s_axis_data_tlast) begin
              state_q <= ST_SYNC;
              idx_q   <= '0;
            end else if (at_last || s_axis_data_tlast) begin
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + ONE_I;
            end
          end
          default: begin
            if (s_axis_data_tlast) begin
              state_q <= ST_RUN;
              idx_q   <= '0;
            end
          end
        endcase
      end
    end
  end

`ifdef AXIS_FMCW_UNFRAME_TUSER_EN
  logic [CNT_WIDTH-1:0] m_tuser_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tuser_q <= '0;
    end else if (s_xfer && state_q == ST_RUN && sel) begin
      m_tuser_q <= idx_q;
    end
  end

  assign m_axis_data_tuser = m_tuser_q;
`else
  // Bin-index sideband not built; nothing extra to register.
`endif

  assign m_axis_data_tdata  = m_tdata_q;
  assign m_axis_data_tvalid = m_tvalid_q;
  assign m_axis_data_tlast  = m_tlast_q;
  assign err_frame          = err_frame_q;
  assign err_count          = err_count_q;

endmodule

// File: tb/tb_axis_fmcw_unframe.sv
// Scoreboard bench for axis_fmcw_unframe: expected bins queued at stimulus time, popped on output.
module tb_axis_fmcw_unframe;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_data;
  logic        err_frame;
  logic [15:0] err_count;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
`ifdef AXIS_FMCW_UNFRAME_TUSER_EN
  logic [11:0] m_tuser;
`endif

  axis_fmcw_unframe #(.AXIS_TDATA_WIDTH(32), .CNT_WIDTH(12)) dut (
    .aclk               (clk),
    .aresetn            (aresetn),
    .cfg_data           (cfg_data),
    .err_frame          (err_frame),
    .err_count          (err_count),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tlast  (s_tlast),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
`ifdef AXIS_FMCW_UNFRAME_TUSER_EN
    .m_axis_data_tuser  (m_tuser),
`endif
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tlast  (m_tlast),
    .m_axis_data_tready (m_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [11:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   in_cyc[256];
  int   rdy_mode = 0;
  bit   mon_en   = 1'b1;
  bit   lat_chk  = 1'b0;
  bit   rdy_chk  = 1'b0;
  int   err_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] make_cfg(input int lg, input int start, input int count);
    logic [31:0] c;
    c = '0;
    c[4:0]   = 5'(lg);
    c[16:5]  = 12'(start);
    c[28:17] = 12'(count);
    return c;
  endfunction

  task automatic expect_beat(input int d, input bit last);
    exp_t e;
    e.data = 32'(d);
    e.last = last;
    e.idx  = 12'(d);
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat transferred.
  task automatic send_beat(input int d, input bit last);
    int waited;
    bit done;
    waited   = 0;
    done     = 1'b0;
    s_tdata  = 32'(d);
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!done) begin
      #4;
      if (s_tready) begin
        done = 1'b1;
        in_cyc[d & 255] = cyc;
      end
      @(negedge clk);
      waited++;
      if (!done && waited > 1000) begin
        check("s_handshake_timeout", 64'(s_tready), 1);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int tlast_at);
    for (int i = 0; i < n; i++) send_beat(i, (i == tlast_at));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      default: m_tready = 1'b0;
    endcase
  end

  // Output monitor: samples just before each rising edge.
  initial begin : monitor
    bit          held = 1'b0;
    bit          prev_err = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #4;
      if (!mon_en || !aresetn) begin
        held = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 64'(m_tvalid), 1);
          check("stall_data", 64'(m_tdata), 64'(held_data));
          check("stall_last", 64'(m_tlast), 64'(held_last));
        end
        held      = m_tvalid && !m_tready;
        held_data = m_tdata;
        held_last = m_tlast;
        if (rdy_chk) check("s_tready", 64'(s_tready), 64'(!m_tvalid || m_tready));
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            check("out_expected", 64'(sb.size() > 0), 1);
          end else begin
            e = sb.pop_front();
            check("tdata", 64'(m_tdata), 64'(e.data));
            check("tlast", 64'(m_tlast), 64'(e.last));
`ifdef AXIS_FMCW_UNFRAME_TUSER_EN
            check("tuser", 64'(m_tuser), 64'(e.idx));
`endif
            if (lat_chk) check("latency", 64'(cyc - in_cyc[m_tdata[7:0]]), 1);
          end
        end
        if (err_frame) begin
          err_pulses++;
          check("err_frame_gap", 64'(prev_err), 0);
        end
        prev_err = err_frame;
      end
    end
  end

  initial begin
    aresetn  = 1'b0;
    cfg_data = make_cfg(3, 2, 3);
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    #4;
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_tlast", 64'(m_tlast), 0);
    check("rst_m_tdata", 64'(m_tdata), 0);
    check("rst_err_frame", 64'(err_frame), 0);
    check("rst_err_count", 64'(err_count), 0);
    check("rst_s_tready", 64'(s_tready), 1);
    @(negedge clk);

    // Two clean frames, full-rate output, latency checked
    lat_chk = 1'b1;
    for (int f = 0; f < 2; f++) begin
      expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
      send_frame(8, 7);
    end
    drain();
    lat_chk = 1'b0;
    check("s1_err_count", 64'(err_count), 0);

    // Same frames under toggling backpressure
    rdy_mode = 1;
    rdy_chk  = 1'b1;
    for (int f = 0; f < 2; f++) begin
      expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
      send_frame(8, 7);
    end
    drain();
    rdy_chk  = 1'b0;
    rdy_mode = 0;
    @(negedge clk);

    // Early tlast on the fifth beat, then a good frame
    expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    send_frame(5, 4);
    expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    send_frame(8, 7);
    drain();
    check("early_err_count", 64'(err_count), 1);
    check("early_err_pulses", 64'(err_pulses), 1);

    // Missing tlast, junk until a tlast, then a good frame
    expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    send_frame(8, -1);
    for (int i = 0; i < 4; i++) send_beat(100 + i, (i == 3));
    expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    send_frame(8, 7);
    drain();
    check("miss_err_count", 64'(err_count), 2);
    check("miss_err_pulses", 64'(err_pulses), 2);

    // Range clipped at frame end; mid-frame cfg change applies next frame
    cfg_data = make_cfg(3, 6, 5);
    expect_beat(6, 0); expect_beat(7, 1);
    send_frame(8, 7);
    expect_beat(6, 0); expect_beat(7, 1);
    for (int i = 0; i < 4; i++) send_beat(i, 1'b0);
    cfg_data = make_cfg(3, 0, 1);
    for (int i = 4; i < 8; i++) send_beat(i, (i == 7));
    expect_beat(0, 1);
    send_frame(8, 7);
    drain();

    // count=0 and start>=size forward nothing and are not errors
    cfg_data = make_cfg(3, 2, 0);
    send_frame(8, 7);
    cfg_data = make_cfg(3, 8, 3);
    send_frame(8, 7);
    drain();
    check("empty_err_count", 64'(err_count), 2);

    // log2 size 13 clamps to 4096 bins
    cfg_data = make_cfg(13, 4094, 5);
    expect_beat(4094, 0); expect_beat(4095, 1);
    send_frame(4096, 4095);
    drain();
    check("clamp_err_count", 64'(err_count), 2);

    // Asynchronous reset mid-frame with a stalled output beat
    cfg_data = make_cfg(3, 2, 3);
    mon_en   = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    #2;
    check("pre_rst_m_tvalid", 64'(m_tvalid), 1);
    aresetn = 1'b0;
    #1;
    check("async_rst_m_tvalid", 64'(m_tvalid), 0);
    check("async_rst_m_tdata", 64'(m_tdata), 0);
    check("async_rst_err_count", 64'(err_count), 0);
    repeat (2) @(negedge clk);
    aresetn  = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    mon_en     = 1'b1;
    err_pulses = 0;
    expect_beat(2, 0); expect_beat(3, 0); expect_beat(4, 1);
    send_frame(8, 7);
    drain();
    check("post_rst_err_count", 64'(err_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
